// File: rtl/mult_xab_datapath.sv
// X/A/B register datapath for the signed shift-add multiplier: adder/subtractor, {X,A,B} shifter, shift counter.
// Build option MULT_PRODUCT_LATCH_EN: Product is a register captured on completion instead of a live {A,B} view.
module mult_xab_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     SW,
    input  logic                 ADD,
    input  logic                 SUB,
    input  logic                 SHIFTXAB,
    input  logic                 ClearXA,
    input  logic                 LoadB,
    output logic                 MBit,
    output logic                 Xval,
    output logic [WIDTH-1:0]     Aval,
    output logic [WIDTH-1:0]     Bval,
    output logic                 ProductValid,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic                 x_q, x_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 capture;

    logic [WIDTH:0]       a_ext;
    logic [WIDTH:0]       sw_ext;
    logic [WIDTH:0]       operand;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       arith;

    // Both operands are sign-extended to WIDTH+1 bits so the sum never overflows and bit WIDTH is the true sign.
    assign a_ext   = {a_q[WIDTH-1], a_q};
    assign sw_ext  = {SW[WIDTH-1], SW};
    assign operand = SUB ? ~sw_ext : sw_ext;
    assign sum     = a_ext + operand + {{WIDTH{1'b0}}, SUB};
    assign arith   = (ADD || SUB) ? sum : {x_q, a_q};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the branches can infer a latch.
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        capture = 1'b0;

        if (ClearXA || LoadB) begin
            if (ClearXA) begin
                x_d = 1'b0;
                a_d = '0;
            end
            if (LoadB) begin
                b_d = SW;
            end
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            x_d = arith[WIDTH];
            a_d = arith[WIDTH-1:0];
            if (SHIFTXAB) begin
                a_d = {arith[WIDTH], arith[WIDTH-1:1]};
                b_d = {arith[0], b_q[WIDTH-1:1]};
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    valid_d = 1'b1;
                    capture = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

`ifdef MULT_PRODUCT_LATCH_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;

    assign prod_d = capture ? {a_d, b_d} : prod_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign Product = prod_q;
`else
    logic unused_capture;

    assign unused_capture = capture;
    assign Product        = {a_q, b_q};
`endif

    assign MBit         = b_q[0];
    assign Xval         = x_q;
    assign Aval         = a_q;
    assign Bval         = b_q;
    assign ProductValid = valid_q;

endmodule

// File: tb/tb_mult_xab_datapath.sv
// Directed bench for mult_xab_datapath: single-cycle vector table plus full multiply, saturation and reset sequences.
module tb_mult_xab_datapath;

    logic        Clk;
    logic        Reset;
    logic [7:0]  SW;
    logic        ADD, SUB, SHIFTXAB, ClearXA, LoadB;
    logic        MBit, Xval, ProductValid;
    logic [7:0]  Aval, Bval;
    logic [15:0] Product;

    int total_cnt = 0;
    int pass_cnt  = 0;

    mult_xab_datapath #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .SW           (SW),
        .ADD          (ADD),
        .SUB          (SUB),
        .SHIFTXAB     (SHIFTXAB),
        .ClearXA      (ClearXA),
        .LoadB        (LoadB),
        .MBit         (MBit),
        .Xval         (Xval),
        .Aval         (Aval),
        .Bval         (Bval),
        .ProductValid (ProductValid),
        .Product      (Product)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] sw;
        logic       add, sub, sh, clr, ld;
        logic       x;
        logic [7:0] a, b;
        logic       pv;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of strobes, clock it, then drop strobes 1 time unit after the edge.
    task automatic step(input logic [7:0] sw, input logic add, sub, sh, clr, ld);
        SW = sw; ADD = add; SUB = sub; SHIFTXAB = sh; ClearXA = clr; LoadB = ld;
        @(posedge Clk);
        #1;
        ADD = 1'b0; SUB = 1'b0; SHIFTXAB = 1'b0; ClearXA = 1'b0; LoadB = 1'b0;
    endtask

    // Plays the control FSM: LoadB, ClearXA, then 8 add/shift pairs with SUB on the last pair.
    task automatic run_mult(input logic [7:0] bv, input logic [7:0] swv, input string nm);
        step(bv, 0, 0, 0, 0, 1);
        step(swv, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (MBit) begin
                step(swv, (i != 7), (i == 7), 0, 0, 0);
            end
            if (i == 7) check({nm, "_pv_before_last"}, ProductValid, 1'b0);
            step(swv, 0, 0, 1, 0, 0);
        end
        check({nm, "_pv_done"}, ProductValid, 1'b1);
    endtask

    initial begin
        SW = '0; ADD = 0; SUB = 0; SHIFTXAB = 0; ClearXA = 0; LoadB = 0;

        vecs[0]  = '{8'h05, 0, 0, 0, 1, 1, 1'b0, 8'h00, 8'h05, 1'b0};
        vecs[1]  = '{8'h7F, 1, 0, 0, 0, 0, 1'b0, 8'h7F, 8'h05, 1'b0};
        vecs[2]  = '{8'h01, 1, 0, 1, 0, 0, 1'b0, 8'h40, 8'h02, 1'b0};
        vecs[3]  = '{8'h02, 1, 1, 0, 0, 0, 1'b0, 8'h3E, 8'h02, 1'b0};
        vecs[4]  = '{8'h80, 0, 1, 0, 0, 0, 1'b0, 8'hBE, 8'h02, 1'b0};
        vecs[5]  = '{8'h7F, 1, 0, 0, 0, 0, 1'b0, 8'h3D, 8'h02, 1'b0};
        vecs[6]  = '{8'h11, 1, 0, 1, 1, 0, 1'b0, 8'h00, 8'h02, 1'b0};
        vecs[7]  = '{8'h01, 0, 1, 0, 0, 0, 1'b1, 8'hFF, 8'h02, 1'b0};
        vecs[8]  = '{8'h00, 0, 0, 1, 0, 0, 1'b1, 8'hFF, 8'h81, 1'b0};
        vecs[9]  = '{8'h80, 0, 1, 0, 0, 0, 1'b0, 8'h7F, 8'h81, 1'b0};
        vecs[10] = '{8'h80, 1, 0, 0, 0, 0, 1'b1, 8'hFF, 8'h81, 1'b0};
        vecs[11] = '{8'h3C, 0, 0, 0, 0, 0, 1'b1, 8'hFF, 8'h81, 1'b0};
        vecs[12] = '{8'hC3, 0, 0, 1, 0, 1, 1'b1, 8'hFF, 8'hC3, 1'b0};
        vecs[13] = '{8'h80, 0, 1, 0, 1, 1, 1'b0, 8'h00, 8'h80, 1'b0};
        vecs[14] = '{8'h80, 0, 1, 0, 0, 0, 1'b0, 8'h80, 8'h80, 1'b0};
        vecs[15] = '{8'h80, 0, 1, 0, 0, 0, 1'b0, 8'h00, 8'h80, 1'b0};
        vecs[16] = '{8'h80, 1, 0, 0, 0, 0, 1'b1, 8'h80, 8'h80, 1'b0};
        vecs[17] = '{8'h80, 1, 0, 0, 0, 0, 1'b1, 8'h00, 8'h80, 1'b0};

        // Power-on reset, observed before any clock edge and after release.
        Reset = 1'b1;
        #3;
        check("por_x", Xval, 1'b0);
        check("por_a", Aval, 8'h00);
        check("por_b", Bval, 8'h00);
        check("por_pv", ProductValid, 1'b0);
        check("por_prod", Product, 16'h0000);
        #9;
        Reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].sw, vecs[i].add, vecs[i].sub, vecs[i].sh, vecs[i].clr, vecs[i].ld);
            check($sformatf("vec%0d_x", i), Xval, vecs[i].x);
            check($sformatf("vec%0d_a", i), Aval, vecs[i].a);
            check($sformatf("vec%0d_b", i), Bval, vecs[i].b);
            check($sformatf("vec%0d_mbit", i), MBit, vecs[i].b[0]);
            check($sformatf("vec%0d_pv", i), ProductValid, vecs[i].pv);
`ifndef MULT_PRODUCT_LATCH_EN
            check($sformatf("vec%0d_prod", i), Product, {vecs[i].a, vecs[i].b});
`endif
        end

        run_mult(8'h03, 8'h07, "m3x7");
        check("m3x7_a", Aval, 8'h00);
        check("m3x7_b", Bval, 8'h15);
        check("m3x7_x", Xval, 1'b0);
        check("m3x7_prod", Product, 16'h0015);

        run_mult(8'hFD, 8'h05, "mn3x5");
        check("mn3x5_a", Aval, 8'hFF);
        check("mn3x5_b", Bval, 8'hF1);
        check("mn3x5_prod", Product, 16'hFFF1);

        run_mult(8'h80, 8'h80, "mn128sq");
        check("mn128sq_prod", Product, 16'h4000);
        check("mn128sq_x", Xval, 1'b0);

        // Ten shifts of {0,0x55,0x96}: completion on the 8th, count saturates, data keeps shifting.
        step(8'h96, 0, 0, 0, 1, 1);
        step(8'h55, 1, 0, 0, 0, 0);
        check("sat_load_a", Aval, 8'h55);
        check("sat_load_b", Bval, 8'h96);
        for (int k = 1; k <= 10; k++) begin
            logic [15:0] live;
            live = 16'h5596 >> k;
            step(8'h00, 0, 0, 1, 0, 0);
            check($sformatf("sat%0d_pv", k), ProductValid, (k >= 8));
            check($sformatf("sat%0d_ab", k), {Aval, Bval}, live);
`ifdef MULT_PRODUCT_LATCH_EN
            check($sformatf("sat%0d_prod", k), Product, (k >= 8) ? 16'h0055 : 16'h4000);
`else
            check($sformatf("sat%0d_prod", k), Product, live);
`endif
        end
        step(8'h00, 0, 0, 0, 1, 0);
        check("sat_clr_pv", ProductValid, 1'b0);
        check("sat_clr_b", Bval, 8'h15);
`ifdef MULT_PRODUCT_LATCH_EN
        check("sat_clr_prod", Product, 16'h0055);
`else
        check("sat_clr_prod", Product, 16'h0015);
`endif

        // Reach completion again, then reset between clock edges.
        step(8'h00, 0, 0, 0, 0, 1);
        step(8'h3C, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(8'h00, 0, 0, 1, 0, 0);
        check("pre_rst_pv", ProductValid, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("rst_x", Xval, 1'b0);
        check("rst_a", Aval, 8'h00);
        check("rst_b", Bval, 8'h00);
        check("rst_pv", ProductValid, 1'b0);
        check("rst_prod", Product, 16'h0000);
        #1;
        Reset = 1'b0;
        step(8'hA5, 0, 0, 0, 0, 0);
        check("idle_a", Aval, 8'h00);
        check("idle_b", Bval, 8'h00);
        check("idle_pv", ProductValid, 1'b0);
        // Count was cleared by reset: a single shift must not complete a product.
        step(8'h00, 0, 0, 1, 0, 0);
        check("rst_cnt_pv", ProductValid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
